// File: rtl/pll_reset_sequencer.sv
// Lock-qualified reset sequencer for the rPLL output domain: releases periph then CPU reset.
// Optional lock-loss event counter enabled by defining PLL_RESET_SEQ_LOSS_CNT_EN.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_CYCLES     = 1024,
    parameter int CPU_DELAY       = 16,
    parameter int SOFT_RST_CYCLES = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    input  logic       soft_rst_req,
    output logic       periph_resetn,
    output logic       cpu_resetn,
    output logic       lock_stable,
    output logic [2:0] state_o,
    output logic [7:0] lock_loss_cnt
);

    localparam int MAX_AB  = (LOCK_CYCLES > CPU_DELAY) ? LOCK_CYCLES : CPU_DELAY;
    localparam int MAX_CYC = (MAX_AB > SOFT_RST_CYCLES) ? MAX_AB : SOFT_RST_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_DELAY - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_RST_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABILIZE = 3'd1,
        PERIPH_UP = 3'd2,
        RUN       = 3'd3,
        SOFT_RST  = 3'd4
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic [CNT_W-1:0]         cnt;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     lock_s;
    logic                     up_next;

    // pll_lock is asynchronous to clk; this chain is its only entry point.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Loss of lock is tested first in every state so it beats soft reset.
    always_comb begin
        next_state = state;
        case (state)
            WAIT_LOCK: if (lock_s) next_state = STABILIZE;
            STABILIZE: begin
                if (!lock_s)                next_state = WAIT_LOCK;
                else if (cnt == LOCK_LAST)  next_state = PERIPH_UP;
            end
            PERIPH_UP: begin
                if (!lock_s)                next_state = WAIT_LOCK;
                else if (cnt == CPU_LAST)   next_state = RUN;
            end
            RUN: begin
                if (!lock_s)                next_state = WAIT_LOCK;
                else if (soft_rst_req)      next_state = SOFT_RST;
            end
            SOFT_RST: begin
                if (!lock_s)                next_state = WAIT_LOCK;
                else if (cnt == SOFT_LAST)  next_state = RUN;
            end
            default:                        next_state = WAIT_LOCK;
        endcase
    end

    assign up_next = (next_state == PERIPH_UP) || (next_state == RUN) ||
                     (next_state == SOFT_RST);

    // Outputs decode next_state so they switch on the same edge as the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            periph_resetn <= 1'b0;
            cpu_resetn    <= 1'b0;
            lock_stable   <= 1'b0;
        end else begin
            state <= next_state;
            if ((next_state != state) || (state == WAIT_LOCK) || (state == RUN)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            periph_resetn <= up_next;
            cpu_resetn    <= (next_state == RUN);
            lock_stable   <= up_next;
        end
    end

    assign state_o = state;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    logic loss_event;

    assign loss_event = !lock_s &&
                        ((state == PERIPH_UP) || (state == RUN) || (state == SOFT_RST));

    // Saturates at 255 and is only cleared by resetn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_loss_cnt <= '0;
        end else if (loss_event && (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`else
    assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: lock-history model plus directed scenarios.
// Loss-count expectations follow PLL_RESET_SEQ_LOSS_CNT_EN when it is defined for the build.
module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int L    = 8;
    localparam int D    = 4;
    localparam int S    = 3;
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    localparam int LOSS_EN = 1;
`else
    localparam int LOSS_EN = 0;
`endif

    logic       clk;
    logic       resetn;
    logic       pll_lock;
    logic       soft_rst_req;
    logic       periph_resetn;
    logic       cpu_resetn;
    logic       lock_stable;
    logic [2:0] state_o;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES(SYNC),
        .LOCK_CYCLES(L),
        .CPU_DELAY(D),
        .SOFT_RST_CYCLES(S)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .pll_lock(pll_lock),
        .soft_rst_req(soft_rst_req),
        .periph_resetn(periph_resetn),
        .cpu_resetn(cpu_resetn),
        .lock_stable(lock_stable),
        .state_o(state_o),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: lock_s is pll_lock as sampled SYNC edges earlier; qual counts consecutive
    // qualified edges, and the phase follows from how far qual has progressed.
    logic hist[SYNC];
    int   qual;
    int   soft_left;
    int   losses;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
            qual      = 0;
            soft_left = 0;
            losses    = 0;
        end else begin
            logic ls;
            logic in_run;
            ls = hist[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = pll_lock;
            if (!ls) begin
                if (qual > L && losses < 255) losses++;
                qual      = 0;
                soft_left = 0;
            end else begin
                in_run = (qual > L + D) && (soft_left == 0);
                if (soft_left > 0)               soft_left--;
                else if (in_run && soft_rst_req) soft_left = S;
                if (qual <= L + D) qual++;
            end
        end
    end

    function automatic int exp_state();
        if (qual == 0)      return 0;
        if (qual <= L)      return 1;
        if (qual <= L + D)  return 2;
        if (soft_left > 0)  return 4;
        return 3;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic lock, input logic req);
        @(negedge clk);
        pll_lock     = lock;
        soft_rst_req = req;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycle-by-cycle comparison against the model whenever the block is out of reset.
    always @(posedge clk) begin
        #1;
        if (resetn) begin
            checkOutput("model_state", int'(state_o), exp_state());
            checkOutput("model_periph", int'(periph_resetn), int'(qual > L));
            checkOutput("model_cpu", int'(cpu_resetn), int'(qual > L + D && soft_left == 0));
            checkOutput("model_lock_stable", int'(lock_stable), int'(qual > L));
            checkOutput("model_loss_cnt", int'(lock_loss_cnt), LOSS_EN * losses);
            checkOutput("order_invariant", int'(cpu_resetn && !periph_resetn), 0);
        end
    end

    task automatic run_power_up(input string tag);
        @(negedge clk);
        resetn       = 1'b1;
        pll_lock     = 1'b1;
        soft_rst_req = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            step(1);
            if (e == 2)  checkOutput({tag, "_state_e2"}, int'(state_o), 0);
            if (e == 3)  checkOutput({tag, "_state_e3"}, int'(state_o), 1);
            if (e == 10) checkOutput({tag, "_periph_e10"}, int'(periph_resetn), 0);
            if (e == 11) begin
                checkOutput({tag, "_periph_e11"}, int'(periph_resetn), 1);
                checkOutput({tag, "_stable_e11"}, int'(lock_stable), 1);
                checkOutput({tag, "_state_e11"}, int'(state_o), 2);
            end
            if (e == 14) checkOutput({tag, "_cpu_e14"}, int'(cpu_resetn), 0);
            if (e == 15) begin
                checkOutput({tag, "_cpu_e15"}, int'(cpu_resetn), 1);
                checkOutput({tag, "_state_e15"}, int'(state_o), 3);
            end
        end
    endtask

    initial begin
        resetn       = 1'b0;
        pll_lock     = 1'b0;
        soft_rst_req = 1'b0;
        #12;
        checkOutput("rst_periph", int'(periph_resetn), 0);
        checkOutput("rst_cpu", int'(cpu_resetn), 0);
        checkOutput("rst_stable", int'(lock_stable), 0);
        checkOutput("rst_state", int'(state_o), 0);
        checkOutput("rst_loss", int'(lock_loss_cnt), 0);

        run_power_up("pwr");

        // Lock glitch while stabilising: drop at cnt=5 for two samples.
        resetn   = 1'b0;
        pll_lock = 1'b0;
        step(2);
        @(negedge clk);
        resetn   = 1'b1;
        pll_lock = 1'b1;
        step(8);
        applyStimulus(1'b0, 1'b0);
        step(2);
        applyStimulus(1'b1, 1'b0);
        for (int r = 1; r <= 11; r++) begin
            step(1);
            if (r == 1) begin
                checkOutput("glitch_state", int'(state_o), 0);
                checkOutput("glitch_periph_r1", int'(periph_resetn), 0);
            end
            if (r == 10) checkOutput("glitch_periph_r10", int'(periph_resetn), 0);
            if (r == 11) checkOutput("glitch_periph_r11", int'(periph_resetn), 1);
        end
        checkOutput("glitch_loss", int'(lock_loss_cnt), 0);
        step(4);
        checkOutput("glitch_cpu_up", int'(cpu_resetn), 1);

        // Lock loss in RUN.
        applyStimulus(1'b0, 1'b0);
        step(2);
        checkOutput("loss_periph_e2", int'(periph_resetn), 1);
        step(1);
        checkOutput("loss_periph_e3", int'(periph_resetn), 0);
        checkOutput("loss_cpu_e3", int'(cpu_resetn), 0);
        checkOutput("loss_state_e3", int'(state_o), 0);
        checkOutput("loss_cnt_1", int'(lock_loss_cnt), LOSS_EN * 1);

        // Soft reset pulse, with a second request inside the pulse.
        applyStimulus(1'b1, 1'b0);
        step(15);
        checkOutput("relock_cpu", int'(cpu_resetn), 1);
        applyStimulus(1'b1, 1'b1);
        step(1);
        checkOutput("soft_cpu_c1", int'(cpu_resetn), 0);
        checkOutput("soft_periph_c1", int'(periph_resetn), 1);
        checkOutput("soft_state_c1", int'(state_o), 4);
        applyStimulus(1'b1, 1'b1);
        step(1);
        checkOutput("soft_cpu_c2", int'(cpu_resetn), 0);
        applyStimulus(1'b1, 1'b0);
        step(1);
        checkOutput("soft_cpu_c3", int'(cpu_resetn), 0);
        checkOutput("soft_periph_c3", int'(periph_resetn), 1);
        step(1);
        checkOutput("soft_cpu_c4", int'(cpu_resetn), 1);
        checkOutput("soft_state_c4", int'(state_o), 3);

        // Soft request arriving together with the synchronized lock drop.
        applyStimulus(1'b0, 1'b0);
        step(2);
        applyStimulus(1'b0, 1'b1);
        step(1);
        checkOutput("prio_state", int'(state_o), 0);
        checkOutput("prio_periph", int'(periph_resetn), 0);
        checkOutput("prio_cpu", int'(cpu_resetn), 0);
        checkOutput("prio_loss", int'(lock_loss_cnt), LOSS_EN * 2);

        // Soft request in PERIPH_UP is ignored, then async reset mid-sequence.
        applyStimulus(1'b1, 1'b0);
        step(11);
        checkOutput("pu_state", int'(state_o), 2);
        applyStimulus(1'b1, 1'b1);
        step(1);
        checkOutput("pu_req_state", int'(state_o), 2);
        checkOutput("pu_req_cpu", int'(cpu_resetn), 0);
        applyStimulus(1'b1, 1'b0);
        step(1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async_periph", int'(periph_resetn), 0);
        checkOutput("async_cpu", int'(cpu_resetn), 0);
        checkOutput("async_stable", int'(lock_stable), 0);
        checkOutput("async_state", int'(state_o), 0);
        checkOutput("async_loss", int'(lock_loss_cnt), 0);
        step(2);
        run_power_up("rerun");

        // 300 loss events from RUN; the counter must saturate.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b0);
            step(3);
            applyStimulus(1'b1, 1'b0);
            step(15);
        end
        checkOutput("sat_loss", int'(lock_loss_cnt), LOSS_EN * 255);
        checkOutput("sat_cpu", int'(cpu_resetn), 1);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
